// File: rtl/tone_sequencer_pkg.sv
// Shared note codes, FSM state encoding and pitch table for tone_sequencer.
package tone_pkg;

   // Note codes with a special meaning; 13 and 14 are also treated as rests.
   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_END  = 4'd15;

   // FSM state encoding.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_PLAY   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // Half period in CLOCK_50 cycles for C4..B4 (codes 1..12); 0 for everything else.
   function automatic logic [16:0] note_half_period(input logic [3:0] code);
      logic [16:0] hp;
      case (code)
         4'd1:    hp = 17'd95556;
         4'd2:    hp = 17'd90194;
         4'd3:    hp = 17'd85131;
         4'd4:    hp = 17'd80353;
         4'd5:    hp = 17'd75843;
         4'd6:    hp = 17'd71586;
         4'd7:    hp = 17'd67568;
         4'd8:    hp = 17'd63776;
         4'd9:    hp = 17'd60196;
         4'd10:   hp = 17'd56818;
         4'd11:   hp = 17'd53629;
         4'd12:   hp = 17'd50619;
         default: hp = 17'd0;
      endcase
      return hp;
   endfunction

   // Codes that produce silence while still consuming a beat.
   function automatic logic note_is_rest(input logic [3:0] code);
      return (code == NOTE_REST) || (code == 4'd13) || (code == 4'd14);
   endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Note ROM bus plus the Audio_Controller sample handshake.
interface tone_sequencer_if #(
   parameter int ADDR_W = 10
) ();
   logic [ADDR_W-1:0]  rom_addr;
   logic [3:0]         rom_data;
   logic               audio_out_allowed;
   logic               write_audio_out;
   logic signed [31:0] left_channel_audio_out;
   logic signed [31:0] right_channel_audio_out;

   // Sequencer side: drives the ROM address and the sample strobe.
   modport master (
      output rom_addr,
      input  rom_data,
      input  audio_out_allowed,
      output write_audio_out,
      output left_channel_audio_out,
      output right_channel_audio_out
   );

   // ROM / Audio_Controller side.
   modport slave (
      input  rom_addr,
      output rom_data,
      output audio_out_allowed,
      input  write_audio_out,
      input  left_channel_audio_out,
      input  right_channel_audio_out
   );
endinterface

// File: rtl/tone_sequencer_sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every SAMPLE_DIV clocks.
module sample_tick_gen #(
   parameter int SAMPLE_DIV = 1042
) (
   input  logic CLOCK_50,
   input  logic reset,
   output logic tick
);
   localparam int              CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0]   LAST = CW'(SAMPLE_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Tick on the last count so the first one lands SAMPLE_DIV-1 cycles after reset.
   assign tick = (cnt_q == LAST);

   // Wrap to zero on the tick, otherwise count up.
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   // Counter register; runs in every sequencer state.
   always_ff @(posedge CLOCK_50) begin
      // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/tone_sequencer.sv
// Plays a note ROM as square-wave tones and feeds samples to Audio_Controller.
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int                 ADDR_W     = 10,
   parameter int                 BEAT_BASE  = 6250000,
   parameter int                 SAMPLE_DIV = 1042,
   parameter logic signed [31:0] AMPLITUDE  = 32'sd10000000,
   parameter bit                 LOOP       = 1'b0
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       speed,
   tone_sequencer_if.master bus,
   output logic             playing,
   output logic             done,
   output logic [7:0]       dropped
);
   // Wide enough for BEAT_BASE << 3.
   localparam int BEAT_W = $clog2(BEAT_BASE) + 4;

   logic [2:0]         state_q,    state_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic [3:0]         note_q,     note_d;
   logic [16:0]        half_q,     half_d;
   logic [BEAT_W-1:0]  beat_q,     beat_d;
   logic [16:0]        tone_q,     tone_d;
   logic               pol_q,      pol_d;
   logic signed [31:0] sample_q,   sample_d;
   logic               pending_q,  pending_d;
   logic [7:0]         dropped_q,  dropped_d;
   logic signed [31:0] tone_sample;
   logic               tick;
   logic               write;

   sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .tick     (tick)
   );

   // Playback FSM: address walk, note decode, beat countdown and square-wave phase.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      note_d     = note_q;
      half_d     = half_q;
      beat_d     = beat_q;
      tone_d     = tone_q;
      pol_d      = pol_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               rom_addr_d = '0;
               state_d    = ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            note_d = bus.rom_data;
            if (bus.rom_data == NOTE_END) begin
               state_d = ST_DONE;
            end else begin
               half_d  = note_half_period(bus.rom_data);
               // Load length-1 so PLAY lasts exactly BEAT_BASE << speed cycles.
               beat_d  = (BEAT_W'(BEAT_BASE) << speed) - BEAT_W'(1);
               tone_d  = '0;
               pol_d   = 1'b0;
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (!note_is_rest(note_q)) begin
               if (tone_q == half_q - 17'd1) begin
                  tone_d = '0;
                  pol_d  = ~pol_q;
               end else begin
                  tone_d = tone_q + 17'd1;
               end
            end
            if (beat_q == '0) begin
               if (rom_addr_q == '1) begin
                  if (LOOP) begin
                     rom_addr_d = '0;
                     state_d    = ST_FETCH;
                  end else begin
                     state_d    = ST_DONE;
                  end
               end else begin
                  rom_addr_d = rom_addr_q + ADDR_W'(1);
                  state_d    = ST_FETCH;
               end
            end else begin
               beat_d = beat_q - BEAT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // stop wins over everything, including a simultaneous start.
      if (stop) state_d = ST_IDLE;
   end

   // Instantaneous tone value: only a sounding note in PLAY is non-zero.
   always_comb begin
      tone_sample = '0;
      if (state_q == ST_PLAY && !note_is_rest(note_q))
         tone_sample = pol_q ? AMPLITUDE : -AMPLITUDE;
   end

   // Sample latch and pending/overrun bookkeeping around the write handshake.
   always_comb begin
      write     = pending_q & bus.audio_out_allowed;
      sample_d  = sample_q;
      pending_d = pending_q;
      dropped_d = dropped_q;
      if (stop || state_q == ST_IDLE || state_q == ST_DONE) begin
         sample_d  = '0;
         pending_d = 1'b0;
      end else if (tick) begin
         // A simultaneous write consumes the old sample, so only an unwritten one is a drop.
         sample_d  = tone_sample;
         pending_d = 1'b1;
         if (pending_q && !write && dropped_q != 8'hFF)
            dropped_d = dropped_q + 8'd1;
      end else if (write) begin
         pending_d = 1'b0;
      end
   end

   // All state registers, synchronously reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rom_addr_q <= '0;
         note_q     <= '0;
         half_q     <= '0;
         beat_q     <= '0;
         tone_q     <= '0;
         pol_q      <= 1'b0;
         sample_q   <= '0;
         pending_q  <= 1'b0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         note_q     <= note_d;
         half_q     <= half_d;
         beat_q     <= beat_d;
         tone_q     <= tone_d;
         pol_q      <= pol_d;
         sample_q   <= sample_d;
         pending_q  <= pending_d;
         dropped_q  <= dropped_d;
      end
   end

   assign bus.rom_addr                = rom_addr_q;
   assign bus.write_audio_out         = write;
   assign bus.left_channel_audio_out  = sample_q;
   assign bus.right_channel_audio_out = sample_q;
   assign playing = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_PLAY);
   assign done    = (state_q == ST_DONE);
   assign dropped = dropped_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: playback timing, tones, handshake, loop, stop and reset.
`timescale 1ns/1ps
module tb_tone_sequencer;
   localparam logic signed [31:0] AMP = 32'sd10000000;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Main instance: 16-word ROM, beat 64, tick every 8.
   logic       start_m, stop_m;
   logic [1:0] speed_m;
   logic       playing_m, done_m;
   logic [7:0] dropped_m;
   logic [3:0] rom_m [16];
   tone_sequencer_if #(.ADDR_W(4)) ifm ();
   tone_sequencer #(.ADDR_W(4), .BEAT_BASE(64), .SAMPLE_DIV(8), .AMPLITUDE(AMP), .LOOP(1'b0)) dut (
      .CLOCK_50(clk), .reset(reset), .start(start_m), .stop(stop_m), .speed(speed_m),
      .bus(ifm), .playing(playing_m), .done(done_m), .dropped(dropped_m));
   always @(posedge clk) ifm.rom_data <= rom_m[ifm.rom_addr];

   // Long-beat instance so a full A4 half period fits inside one note.
   logic       start_t;
   logic       playing_t, done_t;
   logic [7:0] dropped_t;
   logic [3:0] rom_t [16];
   tone_sequencer_if #(.ADDR_W(4)) ift ();
   tone_sequencer #(.ADDR_W(4), .BEAT_BASE(57000), .SAMPLE_DIV(8), .AMPLITUDE(AMP), .LOOP(1'b0)) dut_t (
      .CLOCK_50(clk), .reset(reset), .start(start_t), .stop(1'b0), .speed(2'b00),
      .bus(ift), .playing(playing_t), .done(done_t), .dropped(dropped_t));
   always @(posedge clk) ift.rom_data <= rom_t[ift.rom_addr];

   // Four-word ROM full of code 1, without and with looping.
   logic       start_l;
   logic       playing_l0, done_l0, playing_l1, done_l1;
   logic [7:0] dropped_l0, dropped_l1;
   tone_sequencer_if #(.ADDR_W(2)) ifl0 ();
   tone_sequencer_if #(.ADDR_W(2)) ifl1 ();
   tone_sequencer #(.ADDR_W(2), .BEAT_BASE(64), .SAMPLE_DIV(8), .AMPLITUDE(AMP), .LOOP(1'b0)) dut_l0 (
      .CLOCK_50(clk), .reset(reset), .start(start_l), .stop(1'b0), .speed(2'b00),
      .bus(ifl0), .playing(playing_l0), .done(done_l0), .dropped(dropped_l0));
   tone_sequencer #(.ADDR_W(2), .BEAT_BASE(64), .SAMPLE_DIV(8), .AMPLITUDE(AMP), .LOOP(1'b1)) dut_l1 (
      .CLOCK_50(clk), .reset(reset), .start(start_l), .stop(1'b0), .speed(2'b00),
      .bus(ifl1), .playing(playing_l1), .done(done_l1), .dropped(dropped_l1));

   // Write monitors, sampled on the rising edge (pre-update values).
   int                 wr_m = 0, nz_m = 0;
   logic signed [31:0] last_m = '0, last_r_m = '0, last_t = '0;
   always @(posedge clk) begin
      if (ifm.write_audio_out) begin
         wr_m     <= wr_m + 1;
         last_m   <= ifm.left_channel_audio_out;
         last_r_m <= ifm.right_channel_audio_out;
         if (ifm.left_channel_audio_out != 0) nz_m <= nz_m + 1;
      end
      if (ift.write_audio_out) last_t <= ift.left_channel_audio_out;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start_m();
      start_m = 1'b1;
      cyc(1);
      start_m = 1'b0;
   endtask

   task automatic wait_addr_m(input logic [3:0] a, input int bound, output int n);
      n = 0;
      while (ifm.rom_addr != a && n < bound) begin
         cyc(1);
         n++;
      end
   endtask

   task automatic wait_done_m(input int bound, output int n);
      n = 0;
      while (!done_m && n < bound) begin
         cyc(1);
         n++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, w0, w1, nz0;
      reset   = 1'b1;
      start_m = 1'b0; stop_m = 1'b0; speed_m = 2'b00;
      start_t = 1'b0; start_l = 1'b0;
      ifm.audio_out_allowed  = 1'b1;
      ift.audio_out_allowed  = 1'b1;
      ifl0.audio_out_allowed = 1'b1;
      ifl1.audio_out_allowed = 1'b1;
      ifl0.rom_data = 4'd1;
      ifl1.rom_data = 4'd1;
      for (int i = 0; i < 16; i++) begin
         rom_m[i] = 4'd15;
         rom_t[i] = 4'd15;
      end
      rom_t[0] = 4'd10;

      // Reset state.
      cyc(3);
      check("rst_playing", playing_m, 0);
      check("rst_done", done_m, 0);
      check("rst_addr", ifm.rom_addr, 0);
      check("rst_dropped", dropped_m, 0);
      check("rst_write", ifm.write_audio_out, 0);
      check("rst_left", ifm.left_channel_audio_out, 0);
      reset = 1'b0;
      w0 = wr_m;
      cyc(20);
      check("idle_no_writes", wr_m - w0, 0);

      // 1: A4 then end-of-song, beat 64.
      rom_m[0] = 4'd10; rom_m[1] = 4'd15;
      pulse_start_m();
      check("t1_playing", playing_m, 1);
      cyc(30);
      check("t1_left_low", last_m, -AMP);
      check("t1_right_low", last_r_m, -AMP);
      wait_addr_m(4'd1, 100, n);
      check("t1_cycles_to_addr1", 30 + n, 66);
      wait_done_m(10, n);
      check("t1_done_latency", n, 2);
      check("t1_done", done_m, 1);
      check("t1_not_playing", playing_m, 0);

      // 1b: polarity toggles after 56818 PLAY cycles (PLAY begins 2 cycles after start).
      start_t = 1'b1; cyc(1); start_t = 1'b0;
      cyc(2 + 56818 - 24);
      check("t1b_before_toggle", last_t, -AMP);
      cyc(48);
      check("t1b_after_toggle", last_t, AMP);
      check("t1b_playing", playing_t, 1);
      n = 0;
      while (!done_t && n < 400) begin cyc(1); n++; end
      check("t1b_cycles_to_done", n, 160);

      // 2: rest note writes zeros once per 8 cycles.
      rom_m[0] = 4'd0; rom_m[1] = 4'd15;
      nz0 = nz_m;
      pulse_start_m();
      cyc(4);
      w0 = wr_m;
      cyc(48);
      check("t2_writes_in_48", wr_m - w0, 6);
      wait_done_m(100, n);
      check("t2_done", done_m, 1);
      check("t2_nonzero_writes", nz_m - nz0, 0);

      // 3: back-pressure for 40 cycles during a 128-cycle note.
      rom_m[0] = 4'd10; rom_m[1] = 4'd15;
      speed_m = 2'b01;
      pulse_start_m();
      cyc(3);
      n = 0;
      while (!ifm.write_audio_out && n < 12) begin cyc(1); n++; end
      check("t3_write_seen", ifm.write_audio_out, 1);
      cyc(1);
      ifm.audio_out_allowed = 1'b0;
      w0 = wr_m;
      cyc(40);
      check("t3_blocked_writes", wr_m - w0, 0);
      check("t3_dropped", dropped_m, 4);
      ifm.audio_out_allowed = 1'b1;
      w1 = wr_m;
      cyc(6);
      check("t3_release_writes", wr_m - w1, 1);
      check("t3_release_sample", last_m, -AMP);
      speed_m = 2'b00;
      wait_done_m(300, n);
      check("t3_done", done_m, 1);

      // 4: four-word ROM without / with loop; each note is 2 + 64 cycles.
      start_l = 1'b1; cyc(1); start_l = 1'b0;
      cyc(263);
      check("t4_l0_not_done_yet", done_l0, 0);
      check("t4_l0_addr_last", ifl0.rom_addr, 3);
      cyc(1);
      check("t4_l0_done", done_l0, 1);
      check("t4_l0_addr_held", ifl0.rom_addr, 3);
      check("t4_l0_not_playing", playing_l0, 0);
      check("t4_l1_addr_wrap", ifl1.rom_addr, 0);
      check("t4_l1_playing", playing_l1, 1);
      check("t4_l1_not_done", done_l1, 0);

      // 5: speed 11 latched at DECODE, changed to 00 mid-note.
      rom_m[0] = 4'd1; rom_m[1] = 4'd1; rom_m[2] = 4'd15;
      speed_m = 2'b11;
      pulse_start_m();
      cyc(100);
      speed_m = 2'b00;
      wait_addr_m(4'd1, 600, n);
      check("t5_note0_cycles", 100 + n, 2 + 512);
      wait_addr_m(4'd2, 200, n);
      check("t5_note1_cycles", n, 2 + 64);
      wait_done_m(10, n);
      check("t5_done", done_m, 1);

      // 6: stop and start together during PLAY.
      rom_m[0] = 4'd10; rom_m[1] = 4'd15;
      pulse_start_m();
      cyc(10);
      start_m = 1'b1; stop_m = 1'b1;
      cyc(1);
      start_m = 1'b0; stop_m = 1'b0;
      check("t6_stop_playing", playing_m, 0);
      check("t6_stop_done", done_m, 0);
      check("t6_stop_left", ifm.left_channel_audio_out, 0);
      check("t6_stop_right", ifm.right_channel_audio_out, 0);
      check("t6_stop_write", ifm.write_audio_out, 0);
      w0 = wr_m;
      cyc(20);
      check("t6_idle_writes", wr_m - w0, 0);
      check("t6_still_idle", playing_m, 0);

      // 6b: reset mid-note.
      rom_m[0] = 4'd1; rom_m[1] = 4'd1; rom_m[2] = 4'd15;
      pulse_start_m();
      wait_addr_m(4'd1, 100, n);
      check("t6_addr1_cycles", n, 66);
      cyc(5);
      check("t6_dropped_kept", dropped_m, 4);
      reset = 1'b1;
      cyc(1);
      check("t6_rst_dropped", dropped_m, 0);
      check("t6_rst_addr", ifm.rom_addr, 0);
      check("t6_rst_playing", playing_m, 0);
      check("t6_rst_done_l0", done_l0, 0);
      check("t6_rst_playing_l1", playing_l1, 0);
      check("t6_rst_left", ifm.left_channel_audio_out, 0);
      reset = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Upstream sample source for Audio_Controller.
- Walks a note ROM at a selectable tempo and synthesises a square-wave tone for each note.
- Emits one stereo sample per 48 kHz tick using Audio_Controller's write_audio_out / audio_out_allowed handshake.
- Replaces ad-hoc tone logic in the top level; avconf and Audio_Controller are unchanged.

Parameters:
- ADDR_W, 10, note ROM address width; depth is 2^ADDR_W.
- BEAT_BASE, 6250000, CLOCK_50 cycles per beat at speed 00 (1/8 s).
- SAMPLE_DIV, 1042, CLOCK_50 cycles per sample tick (about 48 kHz).
- AMPLITUDE, 10000000, square-wave magnitude as a signed 32-bit value.
- LOOP, 0, 1 means wrap the address to 0 after the last ROM word instead of finishing.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins playback from address 0.
- stop  in  1  one-cycle pulse; aborts playback.
- speed  in  2  beat length = BEAT_BASE << speed.
- rom_addr  out  ADDR_W  note ROM address (registered).
- rom_data  in  4  note code; valid 1 cycle after rom_addr.
- audio_out_allowed  in  1  Audio_Controller output FIFO has space.
- write_audio_out  out  1  sample write strobe.
- left_channel_audio_out  out  32  signed sample.
- right_channel_audio_out  out  32  signed sample, identical to left.
- playing  out  1  high in FETCH, DECODE and PLAY.
- done  out  1  high in DONE.
- dropped  out  8  saturating count of overwritten samples.

Behaviour:
- Reset values:
  - State IDLE.
  - rom_addr 0.
  - Sample outputs 0.
  - write_audio_out 0, playing 0, done 0, dropped 0.
  - Pending flag 0.
  - All counters 0.
  - Polarity 0.
- Note codes:
  - 0, 13 and 14 are rests (sample value 0).
  - 1..12 are C4..B4.
  - 15 is end-of-song.
- Half periods for codes 1..12, in CLOCK_50 cycles (17-bit): 95556, 90194, 85131, 80353, 75843, 71586, 67568, 63776, 60196, 56818, 53629, 50619.
- FSM:
  - IDLE: on start, rom_addr <= 0, go to FETCH.
  - FETCH: 1 cycle; address is stable. Go to DECODE.
  - DECODE: capture rom_data.
    - Code 15: go to DONE.
    - Otherwise: latch the half period, latch beat length from the current speed, clear the tone counter, set polarity 0, go to PLAY.
  - PLAY: count the beat down.
    - At 0 with rom_addr = max: go to DONE when LOOP=0; otherwise rom_addr <= 0 and go to FETCH.
    - At 0 otherwise: rom_addr++ and go to FETCH.
  - DONE: hold until start (which restarts from address 0, as in IDLE) or stop (go to IDLE).
- stop in any state: next state is IDLE, pending cleared, sample outputs 0. stop takes priority over start in the same cycle.
- start while in FETCH, DECODE or PLAY is ignored.
- Tone generation in PLAY for a non-rest note:
  - The tone counter increments each cycle.
  - At half_period-1 it resets to 0 and polarity toggles.
  - The sample is +AMPLITUDE when polarity is 1, -AMPLITUDE when 0, sign-extended to 32 bits.
  - Rest, and any state other than PLAY, yields sample 0.
- Sample tick:
  - A free-running counter over 0..SAMPLE_DIV-1 generates the tick; it runs in every state.
  - On a tick, the current sample is latched into the output registers and pending is set.
  - In IDLE and DONE, pending is never set and the outputs hold 0.
- Handshake:
  - write_audio_out = pending & audio_out_allowed (combinational from registers).
  - pending clears on the cycle write_audio_out is high.
  - A tick while pending is still set overwrites the sample, keeps pending set, and increments dropped (saturating at 255).
  - A tick and a write in the same cycle: the write consumes the old sample, the new sample is latched, and pending stays 1. This is not a drop.
- The speed change takes effect only at the next DECODE.
- Reset mid-playback returns every output to its reset value on the next edge.

Decomposition:
- tone_pkg holds:
  - Note code constants: NOTE_REST=0, NOTE_END=15.
  - The 12-entry half-period table as a function note_half_period(code) returning 17 bits.
  - FSM state encoding.
- Sub-module sample_tick_gen (parameter SAMPLE_DIV) with output tick.
- Everything else stays in tone_sequencer.

Test Plan:
All scenarios run with BEAT_BASE=64, SAMPLE_DIV=8 unless stated.
1. ROM = {10 (A4), 15}, speed=00, audio_out_allowed=1, start pulse.
   - Polarity toggles every 56818 cycles (run the first half period with the real table).
   - Samples alternate ±10000000 per half period.
   - After 64 beat cycles the block fetches address 1 and done=1 follows.
2. ROM = {0, 15}.
   - All written samples are 0.
   - write_audio_out pulses once per 8 cycles.
3. audio_out_allowed held 0 for 40 cycles during PLAY.
   - No writes occur and dropped = 4.
   - On release, exactly one write of the latest sample.
4. ROM filled with code 1 and no 15, ADDR_W=2, LOOP=0.
   - The block plays addresses 0..3, then done=1 with rom_addr=3.
   - With LOOP=1, rom_addr wraps to 0 and playing stays 1.
5. speed=11 latched at DECODE, changed to 00 mid-note.
   - The current note lasts 512 cycles.
   - The next note lasts 64 cycles.
6. stop and start in the same cycle during PLAY.
   - The block goes to IDLE with outputs 0.
   - Reset asserted mid-note clears dropped, rom_addr and done.
